// File: rtl/fp16_add_sched.sv
// fp16_add_sched: round-robin scheduler feeding one shared fixed-latency FP16 add pipeline, routing sums back by tag.
// Define FP16_SCHED_SPECIAL_EN so that NaN/Inf operand pairs bypass the pipeline with a precomputed result.
module fp16_add_sched #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 16,
  parameter int LAT     = 3
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NUM_REQ-1:0]         s_req_valid,
  output logic [NUM_REQ-1:0]         s_req_ready,
  input  logic [NUM_REQ*DW-1:0]      s_req_a,
  input  logic [NUM_REQ*DW-1:0]      s_req_b,
  output logic                       o_dp_valid,
  output logic [DW-1:0]              o_dp_a,
  output logic [DW-1:0]              o_dp_b,
  input  logic                       i_dp_valid,
  input  logic [DW-1:0]              i_dp_res,
  output logic [NUM_REQ-1:0]         m_res_valid,
  output logic [$clog2(NUM_REQ)-1:0] m_res_id,
  output logic [DW-1:0]              m_res_data,
  input  logic                       i_drain,
  output logic                       o_drained,
  output logic                       o_busy,
  output logic                       o_err
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d, gnt_id, idx;
  logic gnt_found, accept, tag_empty, special, head_byp, head_exp, mism, deliver;
  logic [DW-1:0] gnt_a, gnt_b, head_res;
  logic [LAT:0] tag_v_q, tag_v_d;
  logic [IDW-1:0] tag_id_q [0:LAT];
  logic [IDW-1:0] tag_id_d [0:LAT];
  logic dp_valid_q, dp_valid_d;
  logic [DW-1:0] dp_a_q, dp_a_d, dp_b_q, dp_b_d, res_data_q, res_data_d;
  logic [NUM_REQ-1:0] res_valid_q, res_valid_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic err_q, err_d;
  // Scan downward so the last hit, i.e. the closest requester at or after rr_q, wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id = '0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = IDW'((int'(rr_q) + i) % NUM_REQ);
      if (s_req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id = idx;
      end
    end
  end
  assign accept = aresetn && !i_drain && state_q != DRAIN && gnt_found;
  assign s_req_ready = accept ? ONE << gnt_id : '0;
  assign gnt_a = s_req_a[int'(gnt_id)*DW +: DW];
  assign gnt_b = s_req_b[int'(gnt_id)*DW +: DW];
  assign tag_empty = ~|tag_v_q;
`ifdef FP16_SCHED_SPECIAL_EN
  logic [LAT:0] tag_byp_q, tag_byp_d;
  logic [DW-1:0] tag_res_q [0:LAT];
  logic [DW-1:0] tag_res_d [0:LAT];
  logic a_max, b_max, a_nan, b_nan, a_inf, b_inf;
  logic [DW-1:0] byp_res;
  always_comb begin
    a_max = &gnt_a[DW-2 -: 5];
    b_max = &gnt_b[DW-2 -: 5];
    a_nan = a_max && |gnt_a[DW-7:0];
    b_nan = b_max && |gnt_b[DW-7:0];
    a_inf = a_max && !a_nan;
    b_inf = b_max && !b_nan;
    special = a_max || b_max;
    byp_res = (a_nan || b_nan || (a_inf && b_inf && gnt_a[DW-1] != gnt_b[DW-1])) ? DW'(16'h7E00) : (a_inf ? gnt_a : gnt_b);
    tag_byp_d = {tag_byp_q[LAT-1:0], accept && special};
    tag_res_d[0] = byp_res;
    for (int s = 1; s <= LAT; s++) tag_res_d[s] = tag_res_q[s-1];
    head_byp = tag_byp_q[LAT];
    head_res = tag_res_q[LAT];
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      tag_byp_q <= '0;
      for (int s = 0; s <= LAT; s++) tag_res_q[s] <= '0;
    end else begin
      tag_byp_q <= tag_byp_d;
      tag_res_q <= tag_res_d;
    end
  end
`else
  always_comb begin
    special = 1'b0;
    head_byp = 1'b0;
    head_res = '0;
  end
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = i_drain ? DRAIN : (|s_req_valid ? RUN : IDLE);
      RUN:     state_d = i_drain ? DRAIN : ((!(|s_req_valid) && tag_empty) ? IDLE : RUN);
      DRAIN:   state_d = (!i_drain && tag_empty) ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
    rr_d = accept ? ((gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1) : rr_q;
    dp_valid_d = accept && !special;
    dp_a_d = dp_valid_d ? gnt_a : dp_a_q;
    dp_b_d = dp_valid_d ? gnt_b : dp_b_q;
    tag_v_d = {tag_v_q[LAT-1:0], accept};
    tag_id_d[0] = gnt_id;
    for (int s = 1; s <= LAT; s++) tag_id_d[s] = tag_id_q[s-1];
    // Bypassed slots must see no pipeline strobe; any disagreement is an error and suppresses delivery.
    head_exp = tag_v_q[LAT] && !head_byp;
    mism = i_dp_valid ^ head_exp;
    deliver = tag_v_q[LAT] && !mism;
    res_valid_d = deliver ? ONE << tag_id_q[LAT] : '0;
    res_id_d = deliver ? tag_id_q[LAT] : res_id_q;
    res_data_d = deliver ? (head_byp ? head_res : i_dp_res) : res_data_q;
    err_d = err_q || mism;
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      rr_q <= '0;
      tag_v_q <= '0;
      for (int s = 0; s <= LAT; s++) tag_id_q[s] <= '0;
      dp_valid_q <= 1'b0;
      dp_a_q <= '0;
      dp_b_q <= '0;
      res_valid_q <= '0;
      res_id_q <= '0;
      res_data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      tag_v_q <= tag_v_d;
      tag_id_q <= tag_id_d;
      dp_valid_q <= dp_valid_d;
      dp_a_q <= dp_a_d;
      dp_b_q <= dp_b_d;
      res_valid_q <= res_valid_d;
      res_id_q <= res_id_d;
      res_data_q <= res_data_d;
      err_q <= err_d;
    end
  end
  assign o_dp_valid = dp_valid_q;
  assign o_dp_a = dp_a_q;
  assign o_dp_b = dp_b_q;
  assign m_res_valid = res_valid_q;
  assign m_res_id = res_id_q;
  assign m_res_data = res_data_q;
  assign o_err = err_q;
  assign o_busy = state_q != IDLE || !tag_empty;
  assign o_drained = state_q == DRAIN && tag_empty;
endmodule
